// File: rtl/uv_recon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uv_recon_pkg                                                         |
// | Shared types and constants for the chroma reconstruction sequencer:  |
// | FSM state encoding, coordinate/derr widths, derr field offsets and   |
// | the top/left derr packing helpers.                                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uv_recon_pkg;

  localparam int MB_COORD_W   = 10;
  localparam int DERR_W       = 48;
  localparam int DERR_PACK_W  = 32;
  localparam int DERR_FIELD_W = 8;

  // Channel base offsets inside the 48-bit engine derr word
  localparam int CH0_OFS = 0;
  localparam int CH1_OFS = 24;

  // Field offsets inside one 24-bit channel
  localparam int E0_OFS = 0;
  localparam int E1_OFS = 8;
  localparam int E2_OFS = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_IN  = 2'd1,
    ST_RUN      = 2'd2,
    ST_WAIT_OUT = 2'd3
  } state_t;

  function automatic logic [DERR_FIELD_W-1:0] derr_field(
    input logic [DERR_W-1:0] d,
    input int                ch_ofs,
    input int                e_ofs
  );
    return d[ch_ofs + e_ofs +: DERR_FIELD_W];
  endfunction

  // Word handed to the row below: {c1.e1, c1.e0, c0.e1, c0.e0}
  function automatic logic [DERR_PACK_W-1:0] pack_top(input logic [DERR_W-1:0] d);
    return {derr_field(d, CH1_OFS, E1_OFS), derr_field(d, CH1_OFS, E0_OFS),
            derr_field(d, CH0_OFS, E1_OFS), derr_field(d, CH0_OFS, E0_OFS)};
  endfunction

  // Word handed to the right neighbour: {c1.e2, c1.e0, c0.e2, c0.e0}
  function automatic logic [DERR_PACK_W-1:0] pack_left(input logic [DERR_W-1:0] d);
    return {derr_field(d, CH1_OFS, E2_OFS), derr_field(d, CH1_OFS, E0_OFS),
            derr_field(d, CH0_OFS, E2_OFS), derr_field(d, CH0_OFS, E0_OFS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uv_recon_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uv_recon_sched_if                                                    |
// | Bundle of frame control, upstream/downstream handshakes and engine   |
// | control/derr signals around the reconstruction sequencer.            |
// | master: environment side (upstream, engine, downstream).             |
// | slave : sequencer side.                                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface uv_recon_sched_if;
  import uv_recon_pkg::*;

  logic                   frame_start;
  logic [MB_COORD_W-1:0]  mb_w;
  logic [MB_COORD_W-1:0]  mb_h;
  logic                   in_valid;
  logic                   in_ready;
  logic                   recon_start;
  logic [MB_COORD_W-1:0]  recon_x;
  logic [MB_COORD_W-1:0]  recon_y;
  logic                   recon_done;
  logic [DERR_W-1:0]      recon_derr;
  logic                   top_derr_en;
  logic [MB_COORD_W-1:0]  top_derr_addr;
  logic [DERR_PACK_W-1:0] top_derr;
  logic [DERR_PACK_W-1:0] left_derr;
  logic                   out_valid;
  logic                   out_ready;
  logic                   frame_done;

  modport master (
    output frame_start, mb_w, mb_h, in_valid, recon_done, recon_derr,
           top_derr_en, top_derr_addr, out_ready,
    input  in_ready, recon_start, recon_x, recon_y, top_derr, left_derr,
           out_valid, frame_done
  );

  modport slave (
    input  frame_start, mb_w, mb_h, in_valid, recon_done, recon_derr,
           top_derr_en, top_derr_addr, out_ready,
    output in_ready, recon_start, recon_x, recon_y, top_derr, left_derr,
           out_valid, frame_done
  );

endinterface
`default_nettype wire

// File: rtl/uv_derr_line_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uv_derr_line_buf                                                     |
// | Top-row diffusion-error line buffer: one write port, one registered  |
// | read port with write-first bypass, and a zero-force input that makes |
// | reads return 0 while the first MB row is being processed.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uv_derr_line_buf
  import uv_recon_pkg::*;
#(
  parameter int MAX_MB_W = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [MB_COORD_W-1:0]  wr_addr,
  input  logic [DERR_PACK_W-1:0] wr_data,
  input  logic                   rd_en,
  input  logic [MB_COORD_W-1:0]  rd_addr,
  input  logic                   zero_force,
  output logic [DERR_PACK_W-1:0] rd_data
);

  logic [DERR_PACK_W-1:0] mem [MAX_MB_W];

  // Storage array; contents deliberately survive across frames
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read: zero on row 0, otherwise new data wins on an address collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (zero_force) begin
        rd_data <= '0;
      end else if (wr_en && (wr_addr == rd_addr)) begin
        rd_data <= wr_data;
      end else begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uv_recon_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uv_recon_sched                                                       |
// | Macroblock sequencer for the chroma reconstruction engine: raster    |
// | walk of MB positions, input gating, engine start pulse, downstream   |
// | valid/ready hand-off and diffusion-error neighbour supply.           |
// | Build option: define UV_DERR_EN to include the top-row line buffer   |
// | and left-neighbour derr register; otherwise both outputs read 0.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uv_recon_sched
  import uv_recon_pkg::*;
#(
  parameter int MAX_MB_W = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  uv_recon_sched_if.slave bus
);

  state_t                state;
  state_t                state_next;
  logic [MB_COORD_W-1:0] mb_w_q;
  logic [MB_COORD_W-1:0] mb_h_q;
  logic [MB_COORD_W-1:0] x;
  logic [MB_COORD_W-1:0] y;
  logic                  recon_start_q;
  logic                  frame_done_q;
  logic                  start_next;
  logic                  done_next;
  logic                  load_frame;
  logic                  advance;
  logic                  at_row_end;
  logic                  last_mb;

  assign at_row_end = (x == mb_w_q);
  assign last_mb    = at_row_end && (y == mb_h_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_next = state;
    start_next = 1'b0;
    done_next  = 1'b0;
    load_frame = 1'b0;
    advance    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.frame_start) begin
          state_next = ST_WAIT_IN;
          load_frame = 1'b1;
        end
      end
      ST_WAIT_IN: begin
        if (bus.in_valid) begin
          state_next = ST_RUN;
          start_next = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.recon_done) begin
          state_next = ST_WAIT_OUT;
        end
      end
      ST_WAIT_OUT: begin
        if (bus.out_ready) begin
          if (last_mb) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_WAIT_IN;
            advance    = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // One-cycle pulses for engine start and end of frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recon_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      recon_start_q <= start_next;
      frame_done_q  <= done_next;
    end
  end

  // Frame geometry latch and raster position walk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_w_q <= '0;
      mb_h_q <= '0;
      x      <= '0;
      y      <= '0;
    end else if (load_frame) begin
      mb_w_q <= bus.mb_w;
      mb_h_q <= bus.mb_h;
      x      <= '0;
      y      <= '0;
    end else if (advance) begin
      if (at_row_end) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign bus.in_ready    = (state == ST_WAIT_IN);
  assign bus.out_valid   = (state == ST_WAIT_OUT);
  assign bus.recon_start = recon_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.recon_x     = x;
  assign bus.recon_y     = y;

`ifdef UV_DERR_EN
  logic                   capture;
  logic                   row_wrap;
  logic [DERR_PACK_W-1:0] left_q;
  logic                   wr_en_q;
  logic [MB_COORD_W-1:0]  wr_addr_q;
  logic [DERR_PACK_W-1:0] wr_data_q;

  assign capture  = (state == ST_RUN) && bus.recon_done;
  assign row_wrap = advance && at_row_end;

  // Capture engine derr at done; the line-buffer write lands one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= capture;
      if (capture) begin
        left_q    <= pack_left(bus.recon_derr);
        wr_addr_q <= x;
        wr_data_q <= pack_top(bus.recon_derr);
      end else if (load_frame || row_wrap) begin
        left_q <= '0;
      end
    end
  end

  // Column 0 has no left neighbour
  assign bus.left_derr = (x == '0) ? '0 : left_q;

  uv_derr_line_buf #(
    .MAX_MB_W (MAX_MB_W)
  ) u_line_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en_q),
    .wr_addr    (wr_addr_q),
    .wr_data    (wr_data_q),
    .rd_en      (bus.top_derr_en),
    .rd_addr    (bus.top_derr_addr),
    .zero_force (y == '0),
    .rd_data    (bus.top_derr)
  );
`else
  localparam int unused_max_mb_w = MAX_MB_W;
  logic          unused_derr_inputs;

  assign unused_derr_inputs = ^{bus.recon_derr, bus.top_derr_en, bus.top_derr_addr};
  assign bus.left_derr      = '0;
  assign bus.top_derr       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uv_recon_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uv_recon_sched                                                    |
// | Directed bench for uv_recon_sched with a transaction-level model and |
// | a per-cycle compare process, plus literal spot checks.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uv_recon_sched;

`ifdef UV_DERR_EN
  localparam bit DERR_ON = 1'b1;
`else
  localparam bit DERR_ON = 1'b0;
`endif
  localparam int LAT = 10;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  uv_recon_sched_if bus ();

  uv_recon_sched #(.MAX_MB_W(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Engine derr per (frame, x, y); frame 0 MB (0,0) carries the hand-picked fields
  function automatic logic [47:0] derr_of(input int fr, input int x, input int y);
    logic [7:0] b;
    if (fr == 0 && x == 0 && y == 0) return 48'h7F4405_332211;
    b = 8'(fr * 64 + y * 16 + x * 4 + 1);
    return {b + 8'd5, b + 8'd4, b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // Packing straight from the field layout: e0 [7:0], e1 [15:8], e2 [23:16] per channel
  function automatic logic [31:0] top_of(input logic [47:0] d);
    return {d[39:32], d[31:24], d[15:8], d[7:0]};
  endfunction

  function automatic logic [31:0] left_of(input logic [47:0] d);
    return {d[47:40], d[31:24], d[23:16], d[7:0]};
  endfunction

  // ---------------- model + per-cycle compare ----------------
  int          m_phase = 0;   // 0 idle, 1 awaiting MB, 2 engine busy, 3 awaiting downstream
  int          m_idx   = 0;
  int          m_w     = 1;
  int          m_h     = 1;
  logic [47:0] m_last  = '0;
  bit          exp_start = 1'b0;
  bit          exp_fd    = 1'b0;
  bit          rd_pend   = 1'b0;
  logic [31:0] rd_want   = '0;
  logic [31:0] lb [1024];

  always @(negedge clk) begin : compare
    int cx;
    int cy;
    if (!rst_n) begin
      m_phase   = 0;
      m_idx     = 0;
      exp_start = 1'b0;
      exp_fd    = 1'b0;
      rd_pend   = 1'b0;
      m_last    = '0;
    end else begin
      cx = m_idx % m_w;
      cy = m_idx / m_w;
      chk("in_ready", bus.in_ready, m_phase == 1);
      chk("out_valid", bus.out_valid, m_phase == 3);
      chk("recon_start", bus.recon_start, exp_start);
      chk("frame_done", bus.frame_done, exp_fd);
      if (m_phase != 0) begin
        chk("recon_x", bus.recon_x, cx);
        chk("recon_y", bus.recon_y, cy);
        chk("left_derr", bus.left_derr, (DERR_ON && cx != 0) ? left_of(m_last) : 32'h0);
      end
      if (!DERR_ON) begin
        chk("left_derr_off", bus.left_derr, 32'h0);
        chk("top_derr_off", bus.top_derr, 32'h0);
      end
      if (rd_pend) chk("top_derr", bus.top_derr, rd_want);

      exp_start = 1'b0;
      exp_fd    = 1'b0;
      case (m_phase)
        0: if (bus.frame_start) begin
             m_phase = 1;
             m_idx   = 0;
             m_w     = int'(bus.mb_w) + 1;
             m_h     = int'(bus.mb_h) + 1;
             m_last  = '0;
           end
        1: if (bus.in_valid) begin
             m_phase   = 2;
             exp_start = 1'b1;
           end
        2: if (bus.recon_done) begin
             m_phase = 3;
             m_last  = bus.recon_derr;
             lb[cx]  = top_of(bus.recon_derr);
           end
        3: if (bus.out_ready) begin
             if (m_idx == m_w * m_h - 1) begin
               m_phase = 0;
               exp_fd  = 1'b1;
             end else begin
               m_idx++;
               m_phase = 1;
             end
           end
        default: m_phase = 0;
      endcase
      rd_pend = bus.top_derr_en;
      rd_want = (!DERR_ON || cy == 0) ? 32'h0 : lb[bus.top_derr_addr];
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_mb(input int fr, input int x, input int y, input int hold,
                       input bit spur_done, input bit spur_fs);
    int t;
    if (hold > 0) bus.out_ready = 1'b0;
    if (spur_done) begin
      bus.recon_done = 1'b1;
      tick();
      bus.recon_done = 1'b0;
      chk("spur_done_out_valid", bus.out_valid, 1'b0);
      chk("spur_done_in_ready", bus.in_ready, 1'b1);
    end
    bus.in_valid = 1'b1;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready=%0b expected 1 within 20 cycles", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    // start cycle
    chk("start_pulse", bus.recon_start, 1'b1);
    chk("start_x", bus.recon_x, x);
    chk("start_y", bus.recon_y, y);
    if (fr == 0 && x == 1 && y == 0)
      chk("left_hi_mb10", bus.left_derr[31:16], DERR_ON ? 16'h7F05 : 16'h0);
    if (fr == 0 && x == 0 && y == 1)
      chk("left_mb01", bus.left_derr, 32'h0);
    bus.top_derr_en   = 1'b1;
    bus.top_derr_addr = 10'(x);
    tick();
    bus.top_derr_en = 1'b0;
    if (fr == 0 && x == 0)
      chk("top_lo_col0", bus.top_derr[15:0], (DERR_ON && y == 1) ? 16'h2211 : 16'h0);
    if (spur_fs) begin
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      chk("spur_fs_x", bus.recon_x, x);
      chk("spur_fs_out_valid", bus.out_valid, 1'b0);
    end
    repeat (LAT - (spur_fs ? 2 : 1)) tick();
    bus.recon_derr = derr_of(fr, x, y);
    bus.recon_done = 1'b1;
    tick();
    bus.recon_done    = 1'b0;
    // first output cycle: read back the address being written this edge
    bus.top_derr_en   = 1'b1;
    bus.top_derr_addr = 10'(x);
    tick();
    bus.top_derr_en = 1'b0;
    if (hold > 0) begin
      repeat (hold - 1) tick();
      chk("bp_out_valid", bus.out_valid, 1'b1);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      bus.out_ready = 1'b1;
      tick();
    end
  endtask

  task automatic do_frame(input int fr, input int w1, input int h1, input int hold_idx,
                          input int spur_done_idx, input int spur_fs_idx);
    int idx;
    bus.mb_w        = 10'(w1);
    bus.mb_h        = 10'(h1);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    for (int y = 0; y <= h1; y++) begin
      for (int x = 0; x <= w1; x++) begin
        idx = y * (w1 + 1) + x;
        do_mb(fr, x, y, (idx == hold_idx) ? 20 : 0, idx == spur_done_idx, idx == spur_fs_idx);
      end
    end
    chk("frame_done_after_last", bus.frame_done, 1'b1);
    tick();
    chk("frame_done_one_cycle", bus.frame_done, 1'b0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
    chk({tag, "_recon_start"}, bus.recon_start, 1'b0);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_frame_done"}, bus.frame_done, 1'b0);
    chk({tag, "_recon_x"}, bus.recon_x, 10'd0);
    chk({tag, "_recon_y"}, bus.recon_y, 10'd0);
    chk({tag, "_left_derr"}, bus.left_derr, 32'h0);
    chk({tag, "_top_derr"}, bus.top_derr, 32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst_n             = 1'b0;
    bus.frame_start   = 1'b0;
    bus.mb_w          = '0;
    bus.mb_h          = '0;
    bus.in_valid      = 1'b0;
    bus.recon_done    = 1'b0;
    bus.recon_derr    = '0;
    bus.top_derr_en   = 1'b0;
    bus.top_derr_addr = '0;
    bus.out_ready     = 1'b1;
    repeat (3) tick();
    chk_reset_values("reset");
    rst_n = 1'b1;
    tick();

    // 2x2 frame, spurious done before MB 1
    do_frame(0, 1, 1, -1, 1, -1);
    // 3x2 frame, backpressure on MB 2 (row end), spurious frame_start during MB 1
    do_frame(1, 2, 1, 2, -1, 1);

    // 3x1 frame interrupted by reset while MB (1,0) is running
    bus.mb_w        = 10'd2;
    bus.mb_h        = 10'd0;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    do_mb(2, 0, 0, 0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("pre_reset_x", bus.recon_x, 10'd1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_values("midrun");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // single-MB frame restarts cleanly at (0,0)
    do_frame(3, 0, 0, -1, -1, -1);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
